// File: rtl/phy_pkg.sv
// Shared PHY constants: control symbols, training length and transmitter state encodings.
// The serial receiver imports the same package so both ends agree on the symbols.
package phy_pkg;
    localparam logic [7:0] COM         = 8'hBC;
    localparam logic [7:0] IDL         = 8'h7C;
    localparam logic [2:0] TRAIN_WORDS = 3'd4;

    localparam logic [1:0] ST_TRAIN = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
endpackage

// File: rtl/fifo_2x8.sv
// Two-entry byte FIFO with synchronous active-high reset and a combinational head read.
module fifo_2x8 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_wr_data,
    output logic [7:0] o_rd_data,
    output logic       o_full,
    output logic       o_empty
);
    logic [7:0] r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    // Guarded so a stray push-when-full or pop-when-empty cannot corrupt occupancy.
    assign w_push    = i_push && !o_full;
    assign w_pop     = i_pop && !o_empty;
    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter: 4 COM training words, then buffered payload bytes or IDL fill,
// sent MSB first, one bit per clk_32f cycle with no gaps between words.
import phy_pkg::*;

module paralelo_serial_tx (
    input  logic       clk_32f,
    input  logic       default_values,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       data_out,
    output logic       tx_active,
    output logic [2:0] bit_cnt
);
    logic       r_started;
    logic [2:0] r_bit_cnt;
    logic [2:0] r_com_cnt;
    logic [1:0] r_state;
    logic [6:0] r_shift;
    logic       r_data_out;

    logic       w_boundary;
    logic       w_train;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_empty;
    logic [7:0] w_head;
    logic [7:0] w_word;
    logic [1:0] w_next_state;

    assign ready_out = !w_full && !default_values;
    assign w_push    = valid_in && ready_out;
    assign data_out  = r_data_out;
    assign bit_cnt   = r_bit_cnt;
    assign tx_active = (r_state != ST_TRAIN);

    // The first edge out of reset starts a word without advancing bit_cnt.
    assign w_boundary = !r_started || (r_bit_cnt == 3'd7);
    assign w_train    = (r_com_cnt < TRAIN_WORDS);
    assign w_pop      = w_boundary && !w_train && !w_empty;

    always_comb begin
        w_word       = COM;
        w_next_state = ST_TRAIN;
        if (!w_train) begin
            if (!w_empty) begin
                w_word       = w_head;
                w_next_state = ST_DATA;
            end else begin
                w_word       = IDL;
                w_next_state = ST_IDLE;
            end
        end
    end

    fifo_2x8 u_fifo (
        .i_clk     (clk_32f),
        .i_rst     (default_values),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wr_data (data_in),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk_32f) begin
        if (default_values) begin
            r_started  <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_com_cnt  <= 3'd0;
            r_state    <= ST_TRAIN;
            r_shift    <= 7'd0;
            r_data_out <= 1'b0;
        end else if (w_boundary) begin
            r_started  <= 1'b1;
            r_bit_cnt  <= 3'd0;
            r_state    <= w_next_state;
            r_data_out <= w_word[7];
            r_shift    <= w_word[6:0];
            if (w_train) r_com_cnt <= r_com_cnt + 3'd1;
        end else begin
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            r_data_out <= r_shift[6];
            r_shift    <= {r_shift[5:0], 1'b0};
        end
    end
endmodule

// File: doc/paralelo_serial_tx.md
PARALELO_SERIAL_TX -- requirements
Module: paralelo_serial_tx

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk_32f.
REQ-002 clk_32f  input  1  bit clock; one serial bit is emitted per cycle.
REQ-003 default_values  input  1  synchronous reset, active high.
REQ-004 data_in  input  8  parallel byte from upstream, sampled when valid_in and ready_out are both high.
REQ-005 valid_in  input  1  data_in holds a byte for transmission.
REQ-006 ready_out  output  1  the input buffer can accept a byte this cycle.
REQ-007 data_out  output  1  registered serial line, MSB first, feeding serial_paralelo_phy_rx.
REQ-008 tx_active  output  1  the training sequence is complete.
REQ-009 bit_cnt  output  3  index of the bit currently on data_out, where 0 is the MSB.

Function
REQ-010 Serial stream: 8-bit words back to back with no gaps; the word's bit 7 is on data_out when bit_cnt=0, and bit 0 when bit_cnt=7.
REQ-011 bit_cnt SHALL increment by 1 every cycle and wrap from 7 to 0; the edge at which bit_cnt wraps 7->0 is the word boundary.
REQ-012 Constants: COM=8'hBC, IDL=8'h7C.
REQ-013 FSM states: TRAIN, IDLE, DATA; the state is selected at each word boundary, and at the first post-reset edge, for the word about to start.
REQ-014 TRAIN: the transmitter SHALL send COM exactly 4 times after reset, tracked by a 3-bit com_cnt; after the 4th COM the next word SHALL be chosen from IDLE or DATA.
REQ-015 Word choice after training: if the FIFO is non-empty, pop one byte and send it (DATA); otherwise send IDL (IDLE).
REQ-016 Payload bytes equal to 8'hBC or 8'h7C SHALL be transmitted unmodified, with no escaping.
REQ-017 tx_active SHALL rise on the edge that puts bit 7 of the first post-training word on data_out, and SHALL remain 1 until reset.
REQ-018 Input buffer: 2-entry FIFO; ready_out = !full; a push occurs when valid_in && ready_out.
REQ-019 Bytes MAY be pushed during TRAIN; they are held and sent in order once training ends.
REQ-020 A pop decision SHALL use the occupancy before any same-edge push, so a byte pushed on a boundary edge is not sent until the next boundary.
REQ-021 A simultaneous push and pop on a full FIFO is impossible because ready_out=0; push and pop on the same edge with occupancy 1 SHALL leave occupancy at 1.
REQ-022 Bytes SHALL be transmitted in arrival order, with no loss and no duplication.
REQ-023 Minimum latency: a byte pushed at edge E, with training done and FIFO empty, SHALL appear with bit 7 on data_out at the first word boundary after E, i.e. 1 to 8 cycles later.

Reset
REQ-024 While default_values=1: data_out=0, bit_cnt=0, ready_out=0, tx_active=0, com_cnt=0, FIFO empty, state=TRAIN.
REQ-025 The first rising edge with default_values=0 SHALL set data_out=1 (COM bit 7) and bit_cnt=0.
REQ-026 Reset asserted mid-word or mid-payload SHALL abort the current word, discard FIFO contents, and restart the full 4-COM training.

Structure
REQ-027 COM, IDL, the training count (4) and the state encodings SHALL live in a shared package, phy_pkg, also used by serial_paralelo_phy_rx.
REQ-028 The 2-entry FIFO SHALL be a sub-module, fifo_2x8, with synchronous reset, push/pop ports, and full/empty flags.
REQ-029 The top level SHALL contain the FSM, com_cnt, bit_cnt and an 8-bit shift register; the target size is 120-400 lines total.

Verification
REQ-030 Reset 2 cycles, valid_in=0 -> data_out shows BC,BC,BC,BC,7C,7C... MSB first (first bits 1,0,1,1,1,1,0,0); tx_active rises at cycle 32.
REQ-031 After training, push 8'hA5 one cycle before a boundary -> the next word is A5 (1,0,1,0,0,1,0,1), then 7C.
REQ-032 Hold valid_in=1 with bytes 01,02,03,04 continuously -> ready_out drops when 2 bytes are buffered; the serial output is exactly 01,02,03,04 with no IDL between them.
REQ-033 Push 8'hBC and 8'h7C as payload -> both are sent verbatim; tx_active stays 1.
REQ-034 Assert default_values at bit_cnt=3 of a payload byte with 1 byte buffered -> the next edge gives data_out=0 and ready_out=0; after release, 4 COM words are sent and the buffered byte is never sent.
REQ-035 Loopback into serial_paralelo_phy_rx -> the receiver goes active after training and recovers every pushed byte in order.
